// File: rtl/clk_div_ctrl_if.sv
// Divisor configuration handshake between a divisor source and clk_div_ctrl.
// valid/ready: a divisor transfers on a rising edge where valid and ready are both high;
// valid may be raised, held or dropped freely while ready is low, and nothing transfers then.
interface clk_div_ctrl_if #(
    parameter int W = 24
);
    logic         valid;
    logic [W-1:0] div;
    logic         ready;

    modport master (output valid, output div, input ready);
    modport slave  (input valid, input div, output ready);
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: emits a one-cycle tick every cur_div cycles and a divided clock,
// with divisor changes deferred to the end of the running period.
module clk_div_ctrl #(
    parameter int W           = 24,
    parameter int DEFAULT_DIV = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    clk_div_ctrl_if.slave    cfg,
    output logic             tick,
    output logic             clk_out,
    output logic [W-1:0]     cur_div,
    output logic             busy,
    output logic [1:0]       state_dbg
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } state_t;

    localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);
    localparam logic [W-1:0] MIN_DIV = W'(2);

    state_t       state, state_next;
    logic [W-1:0] cnt, cnt_next;
    logic [W-1:0] pending, pending_next;
    logic [W-1:0] cur_div_next;
    logic [W-1:0] clamped;
    logic [W-1:0] cnt_step;
    logic         tick_next, clk_out_next;
    logic         xfer, terminal;

    assign cfg.ready = (state != SWITCH);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    assign xfer     = cfg.valid && cfg.ready;
    assign clamped  = (cfg.div < MIN_DIV) ? MIN_DIV : cfg.div;
    assign terminal = (cnt == cur_div - W'(1));
    assign cnt_step = terminal ? '0 : cnt + W'(1);

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pending_next = pending;
        cur_div_next = cur_div;
        tick_next    = 1'b0;
        clk_out_next = clk_out;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (xfer) cur_div_next = clamped;
                if (run)  state_next   = RUN;
            end
            RUN: begin
                if (!run) begin
                    // A divisor accepted on the stopping edge takes effect directly.
                    state_next   = IDLE;
                    cnt_next     = '0;
                    clk_out_next = 1'b0;
                    if (xfer) cur_div_next = clamped;
                end else begin
                    cnt_next     = cnt_step;
                    tick_next    = terminal;
                    clk_out_next = clk_out ^ terminal;
                    if (xfer) begin
                        pending_next = clamped;
                        state_next   = SWITCH;
                    end
                end
            end
            SWITCH: begin
                if (!run) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    clk_out_next = 1'b0;
                    cur_div_next = pending;
                end else begin
                    cnt_next     = cnt_step;
                    tick_next    = terminal;
                    clk_out_next = clk_out ^ terminal;
                    if (terminal) begin
                        cur_div_next = pending;
                        state_next   = RUN;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                cnt_next     = '0;
                clk_out_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_div <= DEF_DIV;
            pending <= DEF_DIV;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            cur_div <= cur_div_next;
            pending <= pending_next;
            tick    <= tick_next;
            clk_out <= clk_out_next;
        end
    end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios plus randomized traffic against a
// period-level reference model of the divider.
module tb_clk_div_ctrl;
    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic         run;
    logic         tick;
    logic         clk_out;
    logic [W-1:0] cur_div;
    logic         busy;
    logic [1:0]   state_dbg;

    clk_div_ctrl_if #(.W(W)) cfg_if ();

    clk_div_ctrl #(.W(W), .DEFAULT_DIV(20)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .cfg       (cfg_if.slave),
        .tick      (tick),
        .clk_out   (clk_out),
        .cur_div   (cur_div),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: whether the divider is active, how far into the current period it is,
    // the divisor in effect and an optional deferred divisor.
    bit           m_active;
    int           m_phase;
    logic [W-1:0] m_div;
    logic [W-1:0] m_pend;
    bit           m_pv;
    bit           m_tick;
    bit           m_clk;

    task automatic step_model();
        logic [W-1:0] val;
        bit rdy;
        bit xfer;
        bit ends;
        if (rst === 1'b1) begin
            m_active = 0; m_phase = 0; m_div = W'(20); m_pend = W'(20);
            m_pv = 0; m_tick = 0; m_clk = 0;
        end else begin
            rdy  = !(m_active && m_pv);
            xfer = (cfg_if.valid === 1'b1) && rdy;
            val  = (cfg_if.div < W'(2)) ? W'(2) : cfg_if.div;
            if (!m_active) begin
                m_tick = 0;
                if (xfer) m_div = val;
                if (run === 1'b1) begin
                    m_active = 1;
                    m_phase  = 0;
                end
            end else if (run !== 1'b1) begin
                m_active = 0; m_phase = 0; m_tick = 0; m_clk = 0;
                if (m_pv) begin
                    m_div = m_pend;
                    m_pv  = 0;
                end else if (xfer) begin
                    m_div = val;
                end
            end else begin
                ends = (m_phase + 1 == int'(m_div));
                if (ends) begin
                    m_tick  = 1;
                    m_clk   = !m_clk;
                    m_phase = 0;
                    if (m_pv) begin
                        m_div = m_pend;
                        m_pv  = 0;
                    end
                end else begin
                    m_tick  = 0;
                    m_phase = m_phase + 1;
                end
                if (xfer) begin
                    m_pend = val;
                    m_pv   = 1;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        step_model();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; cfg_if.valid = 1'b0; cfg_if.div = '0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic wait_tick(input int limit, output int at, output bit ok);
        ok = 0;
        at = -1;
        for (int i = 0; i < limit && !ok; i++) begin
            cycle();
            if (tick === 1'b1) begin
                ok = 1;
                at = cyc;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; cfg_if.valid = 1'b1; cfg_if.div = W'(9);
        cycle();
        cycle();
        n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %0d expected 0", tick); end
        n_tests++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL reset_clk_out: got %0d expected 0", clk_out); end
        n_tests++; if (cur_div !== W'(20)) begin n_fail++; $display("FAIL reset_cur_div: got %0d expected 20", cur_div); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0d expected 0", busy); end
        n_tests++; if (cfg_if.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0d expected 1", cfg_if.ready); end
        rst = 1'b0; run = 1'b0; cfg_if.valid = 1'b0;
    endtask

    task automatic test_default_run();
        int t0, at, prev, hi;
        bit ok;
        do_reset();
        run = 1'b1;
        cycle();
        t0 = cyc;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL default_busy: got %0d expected 1", busy); end
        wait_tick(30, at, ok);
        n_tests++; if (!ok || at - t0 != 20) begin n_fail++; $display("FAIL default_first_tick: got %0d expected 20", at - t0); end
        n_tests++; if (clk_out !== 1'b1) begin n_fail++; $display("FAIL default_clk_rise: got %0d expected 1", clk_out); end
        for (int k = 0; k < 3; k++) begin
            prev = at;
            wait_tick(30, at, ok);
            n_tests++; if (!ok || at - prev != 20) begin n_fail++; $display("FAIL default_spacing: got %0d expected 20", at - prev); end
        end
        hi = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (clk_out === 1'b1) hi++;
        end
        n_tests++; if (hi != 20) begin n_fail++; $display("FAIL default_duty: got %0d high of 40 expected 20", hi); end
        n_tests++; if (cur_div !== W'(20)) begin n_fail++; $display("FAIL default_cur_div: got %0d expected 20", cur_div); end
    endtask

    task automatic test_idle_load();
        int t0, at, prev;
        bit ok;
        do_reset();
        cfg_if.valid = 1'b1; cfg_if.div = W'(5);
        cycle();
        cfg_if.valid = 1'b0;
        n_tests++; if (cur_div !== W'(5)) begin n_fail++; $display("FAIL load_cur_div: got %0d expected 5", cur_div); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL load_busy: got %0d expected 0", busy); end
        run = 1'b1;
        cycle();
        t0 = cyc;
        wait_tick(10, at, ok);
        n_tests++; if (!ok || at - t0 != 5) begin n_fail++; $display("FAIL load_first_tick: got %0d expected 5", at - t0); end
        for (int k = 0; k < 2; k++) begin
            prev = at;
            wait_tick(10, at, ok);
            n_tests++; if (!ok || at - prev != 5) begin n_fail++; $display("FAIL load_spacing: got %0d expected 5", at - prev); end
        end
    endtask

    task automatic test_switch();
        int at, prev;
        bit ok;
        do_reset();
        run = 1'b1;
        cycle();
        wait_tick(30, prev, ok);
        for (int k = 0; k < 3; k++) cycle();
        cfg_if.valid = 1'b1; cfg_if.div = W'(8);
        cycle();
        cfg_if.valid = 1'b0;
        n_tests++; if (cfg_if.ready !== 1'b0) begin n_fail++; $display("FAIL switch_ready_low: got %0d expected 0", cfg_if.ready); end
        n_tests++; if (cur_div !== W'(20)) begin n_fail++; $display("FAIL switch_old_div: got %0d expected 20", cur_div); end
        wait_tick(30, at, ok);
        n_tests++; if (!ok || at - prev != 20) begin n_fail++; $display("FAIL switch_old_period: got %0d expected 20", at - prev); end
        n_tests++; if (cfg_if.ready !== 1'b1) begin n_fail++; $display("FAIL switch_ready_back: got %0d expected 1", cfg_if.ready); end
        n_tests++; if (cur_div !== W'(8)) begin n_fail++; $display("FAIL switch_new_div: got %0d expected 8", cur_div); end
        for (int k = 0; k < 2; k++) begin
            prev = at;
            wait_tick(30, at, ok);
            n_tests++; if (!ok || at - prev != 8) begin n_fail++; $display("FAIL switch_new_period: got %0d expected 8", at - prev); end
        end
    endtask

    task automatic test_clamp();
        int t0, at;
        bit ok;
        for (int v = 0; v < 2; v++) begin
            do_reset();
            cfg_if.valid = 1'b1; cfg_if.div = W'(v);
            cycle();
            cfg_if.valid = 1'b0;
            n_tests++; if (cur_div !== W'(2)) begin n_fail++; $display("FAIL clamp_%0d: got %0d expected 2", v, cur_div); end
        end
        run = 1'b1;
        cycle();
        t0 = cyc;
        wait_tick(5, at, ok);
        n_tests++; if (!ok || at - t0 != 2 || clk_out !== 1'b1) begin n_fail++; $display("FAIL clamp_half1: got %0d cycles clk_out %0d expected 2 and 1", at - t0, clk_out); end
        t0 = at;
        wait_tick(5, at, ok);
        n_tests++; if (!ok || at - t0 != 2 || clk_out !== 1'b0) begin n_fail++; $display("FAIL clamp_half2: got %0d cycles clk_out %0d expected 2 and 0", at - t0, clk_out); end
    endtask

    task automatic test_stop_in_switch();
        int at, nt;
        bit ok;
        do_reset();
        run = 1'b1;
        cycle();
        wait_tick(30, at, ok);
        cycle(); cycle();
        cfg_if.valid = 1'b1; cfg_if.div = W'(7);
        cycle();
        n_tests++; if (cfg_if.ready !== 1'b0) begin n_fail++; $display("FAIL stop_ready_low: got %0d expected 0", cfg_if.ready); end
        cfg_if.div = W'(3);
        cycle();
        cfg_if.valid = 1'b0;
        cycle(); cycle();
        run = 1'b0;
        cycle();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %0d expected 0", busy); end
        n_tests++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL stop_clk_out: got %0d expected 0", clk_out); end
        n_tests++; if (cur_div !== W'(7)) begin n_fail++; $display("FAIL stop_cur_div: got %0d expected 7", cur_div); end
        nt = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (tick === 1'b1) nt++;
        end
        n_tests++; if (nt != 0) begin n_fail++; $display("FAIL stop_no_tick: got %0d ticks expected 0", nt); end
        n_tests++; if (cur_div !== W'(7)) begin n_fail++; $display("FAIL stop_ignored_cfg: got %0d expected 7", cur_div); end
    endtask

    task automatic test_reset_mid_run();
        int t0, at, prev;
        bit ok;
        do_reset();
        cfg_if.valid = 1'b1; cfg_if.div = W'(8);
        cycle();
        cfg_if.valid = 1'b0;
        run = 1'b1;
        for (int k = 0; k < 5; k++) cycle();
        cfg_if.valid = 1'b1; cfg_if.div = W'(3);
        cycle();
        cfg_if.valid = 1'b0;
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_tests++; if (cur_div !== W'(20)) begin n_fail++; $display("FAIL rstmid_cur_div: got %0d expected 20", cur_div); end
        n_tests++; if (busy !== 1'b0 || tick !== 1'b0 || clk_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs: got busy %0d tick %0d clk_out %0d expected 0 0 0", busy, tick, clk_out); end
        n_tests++; if (cfg_if.ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %0d expected 1", cfg_if.ready); end
        cycle();
        t0 = cyc;
        wait_tick(30, at, ok);
        n_tests++; if (!ok || at - t0 != 20) begin n_fail++; $display("FAIL rstmid_first_tick: got %0d expected 20", at - t0); end
        prev = at;
        wait_tick(30, at, ok);
        n_tests++; if (!ok || at - prev != 20) begin n_fail++; $display("FAIL rstmid_pending_lost: got %0d expected 20", at - prev); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst          = ($urandom_range(0, 299) == 0);
            run          = ($urandom_range(0, 24) != 0);
            cfg_if.valid = ($urandom_range(0, 5) == 0);
            cfg_if.div   = W'($urandom_range(0, 12));
            cycle();
            n_tests++;
            if (tick !== m_tick || clk_out !== m_clk || cur_div !== m_div ||
                busy !== m_active || cfg_if.ready !== !(m_active && m_pv)) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got tick %0d clk_out %0d cur_div %0d busy %0d ready %0d expected %0d %0d %0d %0d %0d",
                         cyc, tick, clk_out, cur_div, busy, cfg_if.ready,
                         m_tick, m_clk, m_div, m_active, !(m_active && m_pv));
            end
        end
        rst = 1'b0; run = 1'b0; cfg_if.valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; cfg_if.valid = 1'b0; cfg_if.div = '0;
        test_reset();
        test_default_run();
        test_idle_load();
        test_switch();
        test_clamp();
        test_stop_in_switch();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
